// File: rtl/pio_out_blink_pkg.sv
// Register map shared by the blinking output PIO and anything that decodes its bus.
package pio_out_blink_pkg;

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_BLINK_EN = 3'd1;
    localparam logic [2:0] ADDR_PERIOD   = 3'd2;
    localparam logic [2:0] ADDR_OUTSET   = 3'd4;
    localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;
    localparam logic [2:0] ADDR_STATUS   = 3'd6;

endpackage

// File: rtl/pio_out_blink_timer.sv
// Free-running half-period timer: phase flips every period+1 cycles, restarted by load.
module blink_timer #(
    parameter int PERIOD_W = 24
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [PERIOD_W-1:0] period,
    input  logic                load,
    output logic                phase
);

    logic [PERIOD_W-1:0] cnt;

    // NOTE: state flops use non-blocking assignments so every register samples
    // pre-edge values; blocking here would create order-dependent simulation races.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt   <= '0;
            phase <= 1'b1;
        end else if (load) begin
            // A new period restarts the half-period with the output "on",
            // even if the old terminal count lands on this same edge.
            cnt   <= '0;
            phase <= 1'b1;
        end else if (cnt == period) begin
            cnt   <= '0;
            phase <= ~phase;
        end else begin
            cnt   <= cnt + PERIOD_W'(1);
        end
    end

endmodule

// File: rtl/pio_out_blink.sv
// Avalon-MM output PIO with atomic set/clear and per-bit blinking driven by blink_timer.
module pio_out_blink
    import pio_out_blink_pkg::*;
#(
    parameter int          WIDTH        = 8,
    parameter logic [31:0] RESET_VALUE  = 32'h0,
    parameter int          PERIOD_W     = 24,
    parameter logic [31:0] RESET_PERIOD = 32'd12499999
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    logic [WIDTH-1:0]    data;
    logic [WIDTH-1:0]    blink_en;
    logic [PERIOD_W-1:0] period;
    logic                phase;
    logic                wr_en;
    logic                load;
    logic [WIDTH-1:0]    wd;
    logic                unused_writedata;

    assign wr_en = chipselect & ~write_n;
    assign load  = wr_en && (address == ADDR_PERIOD);
    assign wd    = writedata[WIDTH-1:0];

    // Upper writedata bits are deliberately dropped by the register widths.
    assign unused_writedata = ^writedata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data     <= RESET_VALUE[WIDTH-1:0];
            blink_en <= '0;
            period   <= RESET_PERIOD[PERIOD_W-1:0];
        end else if (wr_en) begin
            case (address)
                ADDR_DATA:     data     <= wd;
                ADDR_BLINK_EN: blink_en <= wd;
                ADDR_PERIOD:   period   <= writedata[PERIOD_W-1:0];
                ADDR_OUTSET:   data     <= data | wd;
                ADDR_OUTCLEAR: data     <= data & ~wd;
                default:       ;
            endcase
        end
    end

    blink_timer #(
        .PERIOD_W (PERIOD_W)
    ) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .period  (period),
        .load    (load),
        .phase   (phase)
    );

    // NOTE: readdata gets its default before the case so every path assigns
    // every bit; a missing default in combinational logic infers a latch.
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:     readdata[WIDTH-1:0]    = data;
            ADDR_BLINK_EN: readdata[WIDTH-1:0]    = blink_en;
            ADDR_PERIOD:   readdata[PERIOD_W-1:0] = period;
            ADDR_STATUS:   readdata[0]            = phase;
            default:       ;
        endcase
    end

    assign out_port = data & (~blink_en | {WIDTH{phase}});

endmodule
